// File: rtl/tx_ctrl_module_pkg.sv
// Shared definitions for the UART transmit controller: parity encodings,
// frame FSM states and the parity helper used when a byte is accepted.
package tx_ctrl_module_pkg;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityOdd  = 1;
    localparam int unsigned ParityEven = 2;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitStart = 3'd1,
        StStart     = 3'd2,
        StData      = 3'd3,
        StParity    = 3'd4,
        StStop      = 3'd5
    } tx_state_e;

    // Unused upper bits are zero, so they never disturb the reduction.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == ParityOdd) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/tx_ctrl_module.sv
// UART transmit controller: accepts a byte over valid/ready, requests bit timing
// from the baud generator and serialises start, data, parity and stop bits.
module tx_ctrl_module
    import tx_ctrl_module_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_bps_clk,
    output logic                 tx_count_sig,
    output logic                 tx_pin,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2)
    begin : g_bad_params
        $error("tx_ctrl_module: illegal parameter combination");
    end

    localparam logic [2:0] LastIdx   = 3'(DATA_BITS - 1);
    localparam logic       LastStop  = 1'(STOP_BITS - 1);
    localparam logic       HasParity = (PARITY_MODE != ParityNone);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 par_q, par_d;
    logic [2:0]           idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 pin_q, pin_d;
    logic                 cnt_q, cnt_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        par_d   = par_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        pin_d   = pin_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    sr_d    = tx_data;
                    par_d   = parity_bit(8'(tx_data), PARITY_MODE);
                    cnt_d   = 1'b1;
                    state_d = StWaitStart;
                end
            end
            StWaitStart: begin
                if (tx_bps_clk) begin
                    pin_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tx_bps_clk) begin
                    pin_d   = sr_q[0];
                    sr_d    = sr_q >> 1;
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tx_bps_clk) begin
                    if (idx_q == LastIdx) begin
                        if (HasParity) begin
                            pin_d   = par_q;
                            state_d = StParity;
                        end else begin
                            pin_d   = 1'b1;
                            stop_d  = 1'b0;
                            state_d = StStop;
                        end
                    end else begin
                        // sr_q[0] already holds the next bit after the shift on entry.
                        pin_d = sr_q[0];
                        sr_d  = sr_q >> 1;
                        idx_d = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tx_bps_clk) begin
                    pin_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tx_bps_clk) begin
                    if (stop_q == LastStop) begin
                        cnt_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                pin_d   = 1'b1;
                cnt_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            par_q   <= 1'b0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            pin_q   <= 1'b1;
            cnt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            pin_q   <= pin_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready     = (state_q == StIdle);
    assign tx_count_sig = cnt_q;
    assign tx_pin       = pin_q;
    assign tx_done      = done_q;

endmodule

// File: tb/tb_tx_ctrl_module.sv
// Bench for tx_ctrl_module: five parameter variants, each fed by a BPS=15 baud counter,
// checked every cycle against a bit-period schedule model of the frame.
module tb_tx_ctrl_module;

    localparam int NI = 5;

    function automatic int cfg_db(input int g);
        return (g == 4) ? 5 : 8;
    endfunction

    function automatic int cfg_par(input int g);
        case (g)
            1:       return 2;
            2, 4:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_sb(input int g);
        return (g == 3 || g == 4) ? 2 : 1;
    endfunction

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] valid, ready, bps, force_bps, cnt_sig, pin, done;
    logic [7:0]    data [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned Db = cfg_db(g);
        logic [3:0] bcnt;

        tx_ctrl_module #(
            .DATA_BITS  (Db),
            .PARITY_MODE(cfg_par(g)),
            .STOP_BITS  (cfg_sb(g))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .tx_valid    (valid[g]),
            .tx_ready    (ready[g]),
            .tx_data     (data[g][Db-1:0]),
            .tx_bps_clk  (bps[g]),
            .tx_count_sig(cnt_sig[g]),
            .tx_pin      (pin[g]),
            .tx_done     (done[g])
        );

        // Baud generator stand-in: BPS = 15, strobe at count 7.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           bcnt <= 4'd0;
            else if (!cnt_sig[g]) bcnt <= 4'd0;
            else                  bcnt <= bcnt + 4'd1;
        end
        assign bps[g] = (cnt_sig[g] && bcnt == 4'd7) || force_bps[g];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         acc     [NI];
    bit         active  [NI];
    logic [7:0] mbyte   [NI];
    int         n_acc   [NI];
    int         n_done  [NI];
    int         n_abort [NI];
    int         done_at [NI];

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input int g);
        return 1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g);
    endfunction

    function automatic int done_off(input int g);
        return 8 + 16 * frame_len(g);
    endfunction

    // Expected line level n cycles after the accept edge.
    function automatic logic exp_line(input int g, input int n);
        int j;
        int ones;
        if (n < 8) return 1'b1;
        j = (n - 8) / 16;
        if (j == 0) return 1'b0;
        if (j <= cfg_db(g)) return mbyte[g][j-1];
        if (cfg_par(g) != 0 && j == cfg_db(g) + 1) begin
            ones = $countones(mbyte[g]);
            return (cfg_par(g) == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    function automatic bit is_busy(input int g);
        return active[g] && (cyc - acc[g]) < done_off(g);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle scoreboard on the falling edge; also predicts the next acceptance.
    initial begin
        for (int g = 0; g < NI; g++) begin
            acc[g] = 0; active[g] = 0; mbyte[g] = 0;
            n_acc[g] = 0; n_done[g] = 0; n_abort[g] = 0; done_at[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (!rst_n) begin
                    if (is_busy(g)) n_abort[g]++;
                    active[g] = 0;
                end else begin
                    automatic int n    = cyc - acc[g];
                    automatic bit busy = is_busy(g);
                    check_eq($sformatf("pin[%0d]", g), int'(pin[g]),
                             busy ? int'(exp_line(g, n)) : 1);
                    check_eq($sformatf("count_sig[%0d]", g), int'(cnt_sig[g]), int'(busy));
                    check_eq($sformatf("ready[%0d]", g), int'(ready[g]), int'(!busy));
                    check_eq($sformatf("done[%0d]", g), int'(done[g]),
                             int'(active[g] && n == done_off(g)));
                    if (done[g]) begin
                        n_done[g]++;
                        done_at[g] = cyc;
                    end
                    if (valid[g] && !busy) begin
                        acc[g]    = cyc + 1;
                        active[g] = 1;
                        mbyte[g]  = data[g] & 8'((1 << cfg_db(g)) - 1);
                        n_acc[g]++;
                    end
                end
            end
        end
    end

    task automatic wait_accept(input int g, input int prev);
        int t = 0;
        while (n_acc[g] == prev && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq($sformatf("accept_wait[%0d]", g), int'(n_acc[g] != prev), 1);
    endtask

    task automatic send(input int g, input logic [7:0] b);
        int prev = n_acc[g];
        @(posedge clk); #1;
        valid[g] = 1'b1;
        data[g]  = b;
        wait_accept(g, prev);
        @(posedge clk); #1;
        valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (is_busy(g) && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq($sformatf("idle_wait[%0d]", g), int'(is_busy(g)), 0);
    endtask

    task automatic wait_n(input int g, input int n);
        int t = 0;
        while ((cyc - acc[g]) != n && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq($sformatf("offset_wait[%0d]", g), cyc - acc[g], n);
    endtask

    task automatic toggle_data(input int g, input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            data[g] = 8'($urandom);
        end
    endtask

    task automatic idle_pulses(input int g, input int count);
        repeat (count) begin
            @(posedge clk); #1;
            force_bps[g] = 1'b1;
            @(posedge clk); #1;
            force_bps[g] = 1'b0;
        end
    endtask

    initial begin
        int a1;
        int d0;
        rst_n     = 1'b0;
        valid     = '0;
        force_bps = '0;
        for (int g = 0; g < NI; g++) data[g] = 8'h00;

        #12;
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("rst_pin[%0d]", g), int'(pin[g]), 1);
            check_eq($sformatf("rst_cnt[%0d]", g), int'(cnt_sig[g]), 0);
            check_eq($sformatf("rst_done[%0d]", g), int'(done[g]), 0);
            check_eq($sformatf("rst_ready[%0d]", g), int'(ready[g]), 1);
        end
        #11 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Plain 8N1 frame.
        send(0, 8'hA5);
        wait_idle(0);
        check_eq("t1_done_latency", done_at[0] - acc[0], 168);

        // Even then odd parity on the same byte.
        send(1, 8'h07);
        wait_n(1, 160);
        check_eq("t2_even_parity", int'(pin[1]), 1);
        wait_idle(1);
        check_eq("t2_even_latency", done_at[1] - acc[1], 184);
        send(2, 8'h07);
        wait_n(2, 160);
        check_eq("t2_odd_parity", int'(pin[2]), 0);
        wait_idle(2);
        check_eq("t2_odd_latency", done_at[2] - acc[2], 184);

        // Two stop bits.
        send(3, 8'hFF);
        wait_n(3, 168);
        check_eq("t3_stop_mid", int'(pin[3]), 1);
        wait_idle(3);
        check_eq("t3_done_latency", done_at[3] - acc[3], 184);
        @(negedge clk); #1;
        check_eq("t3_count_after", int'(cnt_sig[3]), 0);

        // Back-to-back with valid held high.
        d0 = n_done[0];
        @(posedge clk); #1;
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        wait_accept(0, n_acc[0] - 0);
        a1 = acc[0];
        @(posedge clk); #1;
        data[0] = 8'hC3;
        wait_accept(0, n_acc[0]);
        check_eq("t4_accept_gap", acc[0] - a1, 169);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        wait_idle(0);
        @(negedge clk); #1;
        check_eq("t4_done_pulses", n_done[0] - d0, 2);

        // Reset in the middle of data bit 4, then a clean frame.
        send(0, 8'h5A);
        wait_n(0, 96);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_pin", int'(pin[0]), 1);
        check_eq("t5_count", int'(cnt_sig[0]), 0);
        check_eq("t5_ready", int'(ready[0]), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 8'hC6);
        wait_idle(0);
        check_eq("t5_done_latency", done_at[0] - acc[0], 168);

        // Data changes after accept and bit strobes while idle.
        send(2, 8'h3B);
        toggle_data(2, 40);
        wait_idle(2);
        idle_pulses(2, 3);
        idle_pulses(4, 2);

        // Randomised frames across all variants.
        for (int i = 0; i < 30; i++) begin
            automatic int g = $urandom_range(0, NI - 1);
            send(g, 8'($urandom));
            if ($urandom_range(0, 1) == 1) toggle_data(g, $urandom_range(1, 60));
            wait_idle(g);
            if ($urandom_range(0, 2) == 0) idle_pulses(g, $urandom_range(1, 2));
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++)
            check_eq($sformatf("done_count[%0d]", g), n_done[g], n_acc[g] - n_abort[g]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
